// File: rtl/mem_block_responder.sv
// Line-organised backing memory for cache refill/write-back traffic.
// One request in flight: optional write-back phase, then optional fill phase, each LATENCY cycles.
module mem_block_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned INDEX_BITS  = 10,
  parameter int unsigned LATENCY     = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_fill,
  input  logic                              req_wb,
  input  logic [DATA_WIDTH-1:0]             fill_addr,
  input  logic [DATA_WIDTH-1:0]             wb_addr,
  input  logic [DATA_WIDTH*BLOCK_WORDS-1:0] wb_data,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [DATA_WIDTH*BLOCK_WORDS-1:0] resp_rdata
);

  localparam int unsigned LW    = DATA_WIDTH * BLOCK_WORDS;
  localparam int unsigned OFF   = $clog2(LW / 8);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic                   req_ready_n, resp_valid_n;
  logic                   accept, wb_done, fill_done;

  logic                   fill_pend;
  logic [INDEX_BITS-1:0]  wb_idx, fill_idx;
  logic [LW-1:0]          wb_line;
  logic [LW-1:0]          mem [0:(1 << INDEX_BITS)-1];

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    accept    = 1'b0;
    wb_done   = 1'b0;
    fill_done = 1'b0;
    unique case (state)
      IDLE: if (req_valid) begin
        accept = 1'b1;
        cnt_n  = CNT_LOAD;
        if (req_wb)        state_n = WB;
        else if (req_fill) state_n = FILL;
        else               state_n = RESP;
      end
      WB: if (cnt == '0) begin
        wb_done = 1'b1;
        if (fill_pend) begin
          state_n = FILL;
          cnt_n   = CNT_LOAD;
        end else begin
          state_n = RESP;
        end
      end else begin
        cnt_n = cnt - 1'b1;
      end
      FILL: if (cnt == '0) begin
        fill_done = 1'b1;
        state_n   = RESP;
      end else begin
        cnt_n = cnt - 1'b1;
      end
      RESP: if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Handshake outputs are registered: derive them from the next state.
    req_ready_n  = (state_n == IDLE);
    resp_valid_n = (state_n == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      req_ready  <= req_ready_n;
      resp_valid <= resp_valid_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_pend  <= 1'b0;
      wb_idx     <= '0;
      fill_idx   <= '0;
      wb_line    <= '0;
      resp_rdata <= '0;
    end else if (accept) begin
      fill_pend  <= req_fill;
      wb_idx     <= wb_addr[INDEX_BITS+OFF-1:OFF];
      fill_idx   <= fill_addr[INDEX_BITS+OFF-1:OFF];
      wb_line    <= wb_data;
      resp_rdata <= '0;
    end else if (fill_done) begin
      resp_rdata <= mem[fill_idx];
    end
  end

  // Array is deliberately unreset; reset forces state to IDLE, which drops an unfinished write.
  always_ff @(posedge clk) begin
    if (wb_done) mem[wb_idx] <= wb_line;
  end

endmodule

// File: tb/tb_mem_block_responder.sv
// Directed self-checking bench for mem_block_responder (LATENCY=4).
module tb_mem_block_responder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_fill, req_wb;
  logic [31:0]  fill_addr, wb_addr;
  logic [127:0] wb_data, resp_rdata;
  logic         resp_valid, resp_ready;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] D1 = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;
  localparam logic [127:0] DX = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] DP = 128'hCAFEF00D_11112222_33334444_55556666;
  localparam logic [127:0] DQ = 128'hBADBAD00_77778888_9999AAAA_BBBBCCCC;

  mem_block_responder #(
    .DATA_WIDTH(32), .BLOCK_WORDS(4), .INDEX_BITS(10), .LATENCY(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fill(req_fill), .req_wb(req_wb),
    .fill_addr(fill_addr), .wb_addr(wb_addr), .wb_data(wb_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Presents one request, scrambles the inputs after acceptance, and counts edges until resp_valid.
  task automatic issue(input logic wb, input logic fill, input logic [31:0] wa,
                       input logic [31:0] fa, input logic [127:0] wd, output int lat);
    req_valid = 1'b1; req_wb = wb; req_fill = fill;
    wb_addr = wa; fill_addr = fa; wb_data = wd;
    step();
    req_valid = 1'b0; req_wb = ~wb; req_fill = ~fill;
    wb_addr = 32'hFFFF_FFF0; fill_addr = 32'hFFFF_FFF0; wb_data = '1;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++; $display("FAIL busy_req_ready: got %b want 0", req_ready);
    end
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 50) begin
      step();
      lat++;
    end
    checks++;
    if (resp_valid !== 1'b1) begin
      failures++; $display("FAIL resp_timeout: resp_valid=%b after %0d edges", resp_valid, lat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_wb = 1'b0; req_fill = 1'b0;
    wb_addr = '0; fill_addr = '0; wb_data = '0; resp_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++;
    if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++;
    if (resp_rdata !== '0) begin failures++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
  endtask

  task automatic test_wb_only();
    int lat;
    resp_ready = 1'b1;
    issue(1'b1, 1'b0, 32'h40, 32'h0, D1, lat);
    checks++;
    if (lat != 4) begin failures++; $display("FAIL wb_latency: got %0d want 4", lat); end
    checks++;
    if (resp_rdata !== '0) begin failures++; $display("FAIL wb_rdata: got %h want 0", resp_rdata); end
    step();
    checks++;
    if (resp_valid !== 1'b0) begin failures++; $display("FAIL wb_one_cycle_valid: got %b want 0", resp_valid); end
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL wb_ready_back: got %b want 1", req_ready); end
  endtask

  task automatic test_fill_hit();
    int lat;
    issue(1'b0, 1'b1, 32'h0, 32'h4C, '0, lat);
    checks++;
    if (lat != 4) begin failures++; $display("FAIL fill_latency: got %0d want 4", lat); end
    checks++;
    if (resp_rdata !== D1) begin failures++; $display("FAIL fill_rdata: got %h want %h", resp_rdata, D1); end
    step();
  endtask

  task automatic test_wb_fill_same();
    int lat;
    issue(1'b1, 1'b1, 32'h80, 32'h84, DX, lat);
    checks++;
    if (lat != 8) begin failures++; $display("FAIL wbfill_latency: got %0d want 8", lat); end
    checks++;
    if (resp_rdata !== DX) begin failures++; $display("FAIL wbfill_rdata: got %h want %h", resp_rdata, DX); end
    step();
    issue(1'b0, 1'b1, 32'h0, 32'h4080, '0, lat);
    checks++;
    if (resp_rdata !== DX) begin failures++; $display("FAIL alias_rdata: got %h want %h", resp_rdata, DX); end
    step();
  endtask

  task automatic test_no_op();
    int lat;
    issue(1'b0, 1'b0, 32'h40, 32'h40, DQ, lat);
    checks++;
    if (resp_rdata !== '0) begin failures++; $display("FAIL noop_rdata: got %h want 0", resp_rdata); end
    step();
  endtask

  task automatic test_backpressure();
    int lat;
    resp_ready = 1'b0;
    issue(1'b0, 1'b1, 32'h0, 32'h40, '0, lat);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== D1 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b rdata=%h want valid=1 ready=0 rdata=%h",
                 i, resp_valid, req_ready, resp_rdata, D1);
      end
    end
    resp_ready = 1'b1;
    step();
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release: valid=%b ready=%b want valid=0 ready=1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_in_wb();
    int lat;
    issue(1'b1, 1'b0, 32'h100, 32'h0, DP, lat);
    step();
    req_valid = 1'b1; req_wb = 1'b1; req_fill = 1'b0; wb_addr = 32'h100; wb_data = DQ;
    step();
    req_valid = 1'b0; req_wb = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL midreset_outputs: valid=%b ready=%b want valid=0 ready=1", resp_valid, req_ready);
    end
    repeat (6) step();
    rst_n = 1'b1;
    step();
    issue(1'b0, 1'b1, 32'h0, 32'h100, '0, lat);
    checks++;
    if (resp_rdata !== DP) begin failures++; $display("FAIL midreset_dropped_wb: got %h want %h", resp_rdata, DP); end
    step();
  endtask

  initial begin
    test_reset();
    test_wb_only();
    test_fill_hit();
    test_wb_fill_same();
    test_no_op();
    test_backpressure();
    test_reset_in_wb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
